// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch queue.
//   fetch_state_t : fetch FSM states (IDLE, REQ, DISCARD)
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   align_word()  : clears the byte-offset bits of an address
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: synchronous first-word-fall-through FIFO of fetch_entry_t.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, wr_data     : write one entry (ignored when full or flushing)
//   pop               : drop the head entry (ignored when empty or flushing)
//   flush             : discard all entries; wins over push and pop
//   rd_data           : head entry, valid whenever empty=0
//   count/full/empty  : occupancy
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    do_push  = push && !flush && (count_q != DEPTH_C);
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty=1 marks the contents as meaningless.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetcher feeding the core.
// Issues one word fetch at a time over mem_req/mem_ack, buffers results with
// their PCs in fetch_fifo and presents them on inst_valid/inst_ready.
// A redirect flushes the buffer and restarts fetch at redirect_pc; a request
// already in flight is completed in DISCARD and its data dropped.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   mem_req/mem_addr            : fetch request, held until mem_ack
//   mem_ack/mem_rdata           : request completion and returned word
//   inst_valid/inst/inst_pc     : head of the prefetch buffer
//   inst_ready                  : core consumes the head
//   redirect/redirect_pc        : taken branch / jump target
//   stat_redirects/stat_stalls  : saturating counters, present only when
//                                 FETCH_STATS_EN is defined (else tied to 0)
module fetch_prefetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [31:0]        stat_redirects,
  output logic [31:0]        stat_stalls
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  fifo_count, count_after;
  logic              fifo_full, fifo_empty;
  logic              room_next;
  fetch_entry_t      push_entry, head_entry;

  assign flush      = redirect;
  // fifo_full never coincides with an ack (no request is issued without room);
  // the term only keeps the push strobe honest.
  assign push       = (state_q == REQ) && mem_ack && !redirect && !fifo_full;
  assign pop        = !fifo_empty && inst_ready && !redirect;
  assign push_entry = '{pc: mem_addr_q, instr: mem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .flush   (flush),
    .rd_data (head_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Occupancy after this cycle's push/pop/flush; a new request may be
  // outstanding next cycle only if this leaves a free slot for its word.
  always_comb begin
    count_after = fifo_count;
    if (flush)               count_after = '0;
    else if (push && !pop)   count_after = fifo_count + CNT_ONE;
    else if (pop && !push)   count_after = fifo_count - CNT_ONE;
  end
  assign room_next = (count_after < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = align_word(redirect_pc);
          state_d    = REQ;
        end else if (room_next) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = align_word(redirect_pc);
          // An ack in the redirect cycle is simply dropped; otherwise the
          // in-flight request must still be completed before refetching.
          state_d    = mem_ack ? REQ : DISCARD;
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = room_next ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) fetch_pc_d = align_word(redirect_pc);
        if (mem_ack)  state_d    = REQ;
      end
      default: state_d = IDLE;
    endcase
    // DISCARD keeps presenting the abandoned address until its ack arrives.
    mem_addr_d = (state_d == DISCARD) ? mem_addr_q : fetch_pc_d;
    mem_req_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? '0 : head_entry.instr;
  assign inst_pc    = fifo_empty ? '0 : head_entry.pc;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_redirects_q, stat_redirects_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_redirects_d = stat_redirects_q;
    stat_stalls_d    = stat_stalls_q;
    if (redirect && (stat_redirects_q != '1))
      stat_redirects_d = stat_redirects_q + 32'd1;
    if (inst_ready && fifo_empty && (stat_stalls_q != '1))
      stat_stalls_d = stat_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_redirects_q <= '0;
      stat_stalls_q    <= '0;
    end else begin
      stat_redirects_q <= stat_redirects_d;
      stat_stalls_q    <= stat_stalls_d;
    end
  end

  assign stat_redirects = stat_redirects_q;
  assign stat_stalls    = stat_stalls_q;
`else
  assign stat_redirects = '0;
  assign stat_stalls    = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue.
// A memory model answers requests with addr ^ 32'hA5A5_0000 after 1..3 cycles.
// The reference model is the instruction stream itself: from reset or from a
// redirect target, the core must see PCs target, target+4, ... in order, each
// with its memory word. The stimulus side queues that expected stream; a
// negedge monitor pops and compares on every accepted instruction and also
// checks request stability, head stability, flush behaviour and counters.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
`ifdef FETCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_redirects;
  logic [31:0] stat_stalls;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stat_redirects (stat_redirects),
    .stat_stalls    (stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_exp_pc;
  logic [31:0] ack_log[$];
  int          n_vec;
  int          n_fail;
  int          pop_count;
  int          mem_lat;     // 0 = random 1..3 per request
  bit          mem_hold;    // memory never acks while set
  int          wait_cnt;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ DATA_KEY;
  endfunction

  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{pc: next_exp_pc, instr: mem_word(next_exp_pc)});
      next_exp_pc = next_exp_pc + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    next_exp_pc = {pc[31:2], 2'b00};
    top_up();
  endtask

  task automatic mem_model();
    if (mem_req && !mem_hold) begin
      if (wait_cnt == 0) wait_cnt = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      wait_cnt--;
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        ack_log.push_back(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) wait_cnt = 0;
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    mem_model();
    top_up();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    sb_restart(tgt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ack_log.delete();
    sb_restart(RESET_PC);
  endtask

  // ---------------- monitor ----------------
  exp_t        e;
  logic        prev_req, prev_ack, prev_redirect, prev_valid, prev_ready;
  logic [31:0] prev_addr, prev_inst, prev_pc;
  logic [31:0] model_redirects, model_stalls;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_redirect = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0;
      model_redirects = '0; model_stalls = '0;
    end else begin
      check("stat_redirects", stat_redirects, STATS_EN ? model_redirects : 32'd0);
      check("stat_stalls", stat_stalls, STATS_EN ? model_stalls : 32'd0);
      if (mem_req) check("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (prev_req && !prev_ack) begin
        check("mem_req_held", {31'd0, mem_req}, 32'd1);
        check("mem_addr_stable", mem_addr, prev_addr);
      end
      if (prev_redirect) check("flush_valid", {31'd0, inst_valid}, 32'd0);
      if (prev_valid && !prev_ready && !prev_redirect) begin
        check("head_valid_held", {31'd0, inst_valid}, 32'd1);
        check("head_inst_stable", inst, prev_inst);
        check("head_pc_stable", inst_pc, prev_pc);
      end
      if (inst_valid && inst_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst", inst, e.instr);
          pop_count++;
        end
      end
      if (redirect) model_redirects++;
      if (inst_ready && !inst_valid) model_stalls++;
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      prev_redirect = redirect; prev_valid = inst_valid; prev_ready = inst_ready;
      prev_inst = inst; prev_pc = inst_pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int start_pops;
    int i;
    n_vec = 0; n_fail = 0; pop_count = 0;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_lat = 1; mem_hold = 1'b0; wait_cnt = 0;
    sb_restart(RESET_PC);

    // Reset state
    do_reset();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // 1-cycle memory, core not ready: first-word latency, then fill and stop
    for (i = 0; i < 20 && !mem_ack; i++) tick();
    check("first_ack_seen", {31'd0, mem_ack}, 32'd1);
    check("valid_before_ack", {31'd0, inst_valid}, 32'd0);
    tick();
    check("latency_valid", {31'd0, inst_valid}, 32'd1);
    check("latency_pc", inst_pc, 32'h0);
    check("latency_inst", inst, 32'hA5A5_0000);
    repeat (8) tick();
    check("full_ack_count", ack_log.size(), 32'd4);
    check("full_mem_req", {31'd0, mem_req}, 32'd0);
    for (int k = 0; k < 4; k++)
      if (k < ack_log.size()) check("fill_addr", ack_log[k], 32'(k * 4));
    start_pops = pop_count;
    inst_ready = 1'b1;
    repeat (12) tick();
    check("resume_addr_10", (ack_log.size() > 4) ? ack_log[4] : 32'hDEAD_BEEF, 32'h10);
    check("resume_pops", {31'd0, (pop_count - start_pops) >= 5}, 32'd1);

    // Redirect while the request to 0x8 is pending on a 3-cycle memory
    mem_lat = 3;
    do_reset();
    inst_ready = 1'b1;
    for (i = 0; i < 40 && !(mem_req && mem_addr == 32'h8 && !mem_ack); i++) tick();
    check("pending_8_seen", {31'd0, mem_req && mem_addr == 32'h8 && !mem_ack}, 32'd1);
    do_redirect(32'h40);
    tick();
    for (i = 0; i < 10 && !mem_ack; i++) tick();
    check("discard_ack_seen", {31'd0, mem_ack}, 32'd1);
    check("discard_addr", mem_addr, 32'h8);
    tick();
    check("after_discard_req", {31'd0, mem_req}, 32'd1);
    check("after_discard_addr", mem_addr, 32'h40);
    for (i = 0; i < 20 && !inst_valid; i++) tick();
    check("redirect_first_pc", inst_pc, 32'h40);

    // redirect, mem_ack and inst_ready in the same cycle
    mem_lat = 1;
    do_reset();
    inst_ready = 1'b1;
    for (i = 0; i < 20 && !(mem_ack && inst_valid); i++) tick();
    check("triple_seen", {31'd0, mem_ack && inst_valid}, 32'd1);
    do_redirect(32'h100);
    tick();
    check("triple_flush_valid", {31'd0, inst_valid}, 32'd0);
    for (i = 0; i < 20 && !inst_valid; i++) tick();
    check("triple_first_pc", inst_pc, 32'h100);

    // Unaligned target and fetch PC wrap
    do_redirect(32'h43);
    tick();
    check("align_addr", mem_addr, 32'h40);
    do_redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_top_addr", mem_addr, 32'hFFFF_FFFC);
    check("wrap_top_ack", {31'd0, mem_ack}, 32'd1);
    tick();
    check("wrap_next_req", {31'd0, mem_req}, 32'd1);
    check("wrap_next_addr", mem_addr, 32'h0);
    repeat (6) tick();

    // Reset while a request is outstanding
    mem_lat = 3;
    for (i = 0; i < 20 && !(mem_req && !mem_ack); i++) tick();
    reset = 1'b1;
    tick();
    check("reset_drops_req", {31'd0, mem_req}, 32'd0);
    check("reset_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    reset = 1'b0;
    ack_log.delete();
    sb_restart(RESET_PC);
    repeat (10) tick();

    // Counters: 3 redirects, then 5 starved ready cycles
    mem_lat = 1;
    inst_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    mem_hold = 1'b1;
    do_redirect(32'h200); tick();
    do_redirect(32'h300); tick();
    do_redirect(32'h400); tick();
    inst_ready = 1'b1;
    repeat (5) tick();
    inst_ready = 1'b0;
    check("stats_redirects_3", stat_redirects, STATS_EN ? 32'd3 : 32'd0);
    check("stats_stalls_5", stat_stalls, STATS_EN ? 32'd5 : 32'd0);
    mem_hold = 1'b0;
    repeat (4) tick();

    // Randomized traffic
    mem_lat = 0;
    start_pops = pop_count;
    for (int c = 0; c < 1500; c++) begin
      tick();
      inst_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 4) do_redirect($urandom);
    end
    check("random_progress", {31'd0, (pop_count - start_pops) > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
